// File: rtl/template_capture_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : template_capture_pkg
//  Purpose  : Shared constants and FSM state type for the template capture
//             block (window geometry, cell grid, datapath widths).
//  Revision : 1.0 - initial release
// ============================================================================
package template_capture_pkg;

    localparam int GRID       = 16;              // cells per row / column
    localparam int CELL_SHIFT = 3;               // 8x8 pixels per cell
    localparam int WIN        = 128;             // window size in pixels
    localparam int ADDR_W     = 8;               // template RAM address width
    localparam int PIX_W      = 10;              // pixel / cell value width
    localparam int ACC_W      = 16;              // cell accumulator width
    localparam int COORD_W    = 13;              // camera coordinate width
    localparam int LOC_W      = $clog2(WIN);     // in-window coordinate width
    localparam int CELL_W     = LOC_W - CELL_SHIFT; // cell index width

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

endpackage : template_capture_pkg
`default_nettype wire

// File: rtl/template_capture_cell_accum_bank.sv
`default_nettype none
// ============================================================================
//  Module   : cell_accum_bank
//  Purpose  : One cell-row of box-filter accumulators (GRID entries of ACC_W
//             bits). The entry selected by i_sel either loads or adds i_data.
//             o_sum is the post-update value of the selected entry, so the
//             caller can form the cell result in the same cycle as the last
//             pixel of the cell.
//  Ports    : clk, rst_n      - clock, asynchronous active-low reset
//             i_sel          - cell column being updated / read
//             i_load         - start a new cell (entry := i_data)
//             i_add          - continue a cell (entry += i_data)
//             i_data         - pixel intensity
//             o_sum          - selected entry after this cycle's update
//  Revision : 1.0 - initial release
// ============================================================================
module cell_accum_bank
    import template_capture_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CELL_W-1:0] i_sel,
    input  logic              i_load,
    input  logic              i_add,
    input  logic [PIX_W-1:0]  i_data,
    output logic [ACC_W-1:0]  o_sum
);

    logic [ACC_W-1:0] acc_q [GRID];
    logic [ACC_W-1:0] acc_d [GRID];
    logic [ACC_W-1:0] w_base;

    always_comb begin
        acc_d  = acc_q;
        w_base = i_load ? '0 : acc_q[i_sel];
        // 64 pixels of at most 1023 sum to < 2^16, so no overflow is possible
        o_sum  = w_base + ACC_W'(i_data);
        if (i_load || i_add) begin
            acc_d[i_sel] = o_sum;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < GRID; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule : cell_accum_bank
`default_nettype wire

// File: rtl/template_capture.sv
`default_nettype none
// ============================================================================
//  Module   : template_capture
//  Purpose  : Downsamples a 128x128 camera window at (X0,Y0) into a 16x16
//             template and writes it, one cell per write, to an external RAM
//             in raster order (address = cellY*16 + cellX).
//             Build option TEMPLATE_CAPTURE_AVG_EN:
//               defined   - each cell is the truncated mean of its 8x8 pixels
//               undefined - each cell is the top-left pixel of the cell
//  Ports    : iCLK, iRST_N   - clock, asynchronous active-low reset
//             iX, iY, iDATA  - camera sample coordinates and intensity
//             iDVAL          - sample valid
//             iSTART         - capture request (honoured in IDLE only)
//             oWR_EN/ADDR/DATA - template RAM write port
//             oBUSY          - armed or capturing
//             oDONE          - one-cycle pulse after the final write
//  Revision : 1.0 - initial release
// ============================================================================
module template_capture
    import template_capture_pkg::*;
#(
    parameter int X0 = 0,
    parameter int Y0 = 0
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    input  logic [COORD_W-1:0] iX,
    input  logic [COORD_W-1:0] iY,
    input  logic [PIX_W-1:0]   iDATA,
    input  logic               iDVAL,
    input  logic               iSTART,
    output logic               oWR_EN,
    output logic [ADDR_W-1:0]  oWR_ADDR,
    output logic [PIX_W-1:0]   oWR_DATA,
    output logic               oBUSY,
    output logic               oDONE
);

    localparam logic [COORD_W:0] X0_EXT  = (COORD_W+1)'(X0);
    localparam logic [COORD_W:0] Y0_EXT  = (COORD_W+1)'(Y0);
    localparam logic [COORD_W:0] WIN_EXT = (COORD_W+1)'(WIN);

    // ------------------------------------------------------------------
    // Window decode. The subtraction is one bit wider than the coordinate
    // so that a sample left of / above the origin wraps to a large value
    // and fails the single "< WIN" test.
    // ------------------------------------------------------------------
    logic [COORD_W:0]  w_lx_full;
    logic [COORD_W:0]  w_ly_full;
    logic [LOC_W-1:0]  w_lx;
    logic [LOC_W-1:0]  w_ly;
    logic [CELL_W-1:0] w_cell_x;
    logic [CELL_W-1:0] w_cell_y;
    logic              w_in_win;
    logic              w_origin;
    logic              w_sub_first;   // top-left pixel of a cell

    assign w_lx_full   = {1'b0, iX} - X0_EXT;
    assign w_ly_full   = {1'b0, iY} - Y0_EXT;
    assign w_lx        = w_lx_full[LOC_W-1:0];
    assign w_ly        = w_ly_full[LOC_W-1:0];
    assign w_cell_x    = w_lx[LOC_W-1:CELL_SHIFT];
    assign w_cell_y    = w_ly[LOC_W-1:CELL_SHIFT];
    assign w_in_win    = iDVAL && (w_lx_full < WIN_EXT) && (w_ly_full < WIN_EXT);
    assign w_origin    = w_in_win && (w_lx == '0) && (w_ly == '0);
    assign w_sub_first = (w_lx[CELL_SHIFT-1:0] == '0) && (w_ly[CELL_SHIFT-1:0] == '0);

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_e            state_q, state_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [PIX_W-1:0]  wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              w_proc;        // this sample contributes to the template
    logic              w_trig;        // this sample completes a cell
    logic [PIX_W-1:0]  w_cell_val;

`ifdef TEMPLATE_CAPTURE_AVG_EN
    logic              w_sub_last;    // bottom-right pixel of a cell
    logic [ACC_W-1:0]  w_sum;

    assign w_sub_last = (w_lx[CELL_SHIFT-1:0] == '1) && (w_ly[CELL_SHIFT-1:0] == '1);

    // A cell-row of accumulators suffices: rows of one cell row are
    // finished before the next cell row begins.
    cell_accum_bank u_accum (
        .clk    (iCLK),
        .rst_n  (iRST_N),
        .i_sel  (w_cell_x),
        .i_load (w_proc && w_sub_first),
        .i_add  (w_proc && !w_sub_first),
        .i_data (iDATA),
        .o_sum  (w_sum)
    );

    assign w_trig     = w_proc && w_sub_last;
    // Divide by 64 pixels: keep the top PIX_W bits of the sum
    assign w_cell_val = w_sum[ACC_W-1 -: PIX_W];
`else
    assign w_trig     = w_proc && w_sub_first;
    assign w_cell_val = iDATA;
`endif

    always_comb begin
        state_d = state_q;
        w_proc  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (iSTART) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                // The origin sample starts the capture and is itself used
                if (w_origin) begin
                    state_d = ST_CAPTURE;
                    w_proc  = 1'b1;
                end
            end
            ST_CAPTURE: begin
                // A fresh origin here simply restarts: the accumulators
                // reload and the address follows the raster back to 0.
                w_proc = w_in_win;
                if (wr_en_q && (wr_addr_q == '1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        wr_en_d   = w_trig;
        wr_addr_d = w_trig ? {w_cell_y, w_cell_x} : wr_addr_q;
        wr_data_d = w_trig ? w_cell_val : wr_data_q;
        busy_d    = (state_d == ST_ARM) || (state_d == ST_CAPTURE);
        done_d    = (state_d == ST_DONE);
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q   <= ST_IDLE;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign oWR_EN   = wr_en_q;
    assign oWR_ADDR = wr_addr_q;
    assign oWR_DATA = wr_data_q;
    assign oBUSY    = busy_q;
    assign oDONE    = done_q;

endmodule : template_capture
`default_nettype wire

// File: doc/template_capture.md
TEMPLATE_CAPTURE -- requirements
Module: template_capture

Interface
REQ-001 Parameter X0, default 0: window left edge, in camera pixels.
REQ-002 Parameter Y0, default 0: window top edge, in camera pixels.
REQ-003 Port iCLK, input, 1: sole clock; all logic on rising edge.
REQ-004 Port iRST_N, input, 1: reset, asynchronous and active-low.
REQ-005 Port iX, input, 13: pixel column of the current camera sample.
REQ-006 Port iY, input, 13: pixel row of the current camera sample.
REQ-007 Port iDATA, input, 10: pixel intensity.
REQ-008 Port iDVAL, input, 1: iX/iY/iDATA valid this cycle.
REQ-009 Port iSTART, input, 1: single-cycle capture request.
REQ-010 Port oWR_EN, output, 1: template RAM write strobe, one cycle per cell.
REQ-011 Port oWR_ADDR, output, 8: cell address = cellY*16 + cellX, matching the template reader's memPos layout.
REQ-012 Port oWR_DATA, output, 10: cell value.
REQ-013 Port oBUSY, output, 1: capture armed or in progress.
REQ-014 Port oDONE, output, 1: one-cycle pulse after the 256th write.

Function
REQ-015 The block SHALL downsample a 128x128 camera window at (X0,Y0) into a 16x16 template, with 8x8 pixels per cell (shift 3), and write it to an external RAM.
REQ-016 The block SHALL treat a sample as in-window when iDVAL=1, X0<=iX<X0+128 and Y0<=iY<Y0+128; local lx=iX-X0, ly=iY-Y0; cellX=lx>>3, cellY=ly>>3.
REQ-017 The FSM SHALL have the states IDLE, ARM, CAPTURE and DONE.
- IDLE->ARM on iSTART=1.
- ARM->CAPTURE on an in-window sample with lx=0 and ly=0, which is also processed as the first sample.
- CAPTURE->DONE in the cycle after the write to address 255.
- DONE->IDLE unconditionally after one cycle.
REQ-018 iSTART SHALL be ignored outside IDLE.
REQ-019 Samples with iDVAL=0 or outside the window SHALL not alter accumulators or counters; such samples only stall the capture.
REQ-020 In averaging mode, the block SHALL keep 16 unsigned 16-bit cell accumulators for the current cell-row.
- At lx%8=0 and ly%8=0 the accumulator SHALL load iDATA; other in-window samples add iDATA.
REQ-021 On the sample with lx%8=7 and ly%8=7, the block SHALL assert oWR_EN in the next cycle, with oWR_ADDR = {cellY,cellX} and oWR_DATA = (acc+iDATA)>>6 (truncating); write latency is 1 cycle.
REQ-022 Writes SHALL occur in ascending address order, 0..255, exactly once each per capture.
REQ-023 An in-window sample with lx=0 and ly=0 seen in CAPTURE (frame restart before completion) SHALL restart the capture: accumulators reload, and the next write is address 0 again; no oDONE is issued for the aborted frame.
REQ-024 oBUSY SHALL be 1 in ARM and CAPTURE and 0 otherwise; oDONE SHALL be 1 only in DONE.
REQ-025 oWR_ADDR and oWR_DATA SHALL hold their last values while oWR_EN=0.

Reset
REQ-026 iRST_N=0 SHALL force, immediately and also mid-capture:
- IDLE state.
- oWR_EN=0, oWR_ADDR=0, oWR_DATA=0, oBUSY=0, oDONE=0.
- All accumulators = 0.
REQ-027 After reset release, no write SHALL occur until a fresh iSTART followed by a window origin sample.

Configuration
REQ-028 The block SHALL support the macro TEMPLATE_CAPTURE_AVG_EN.
- Defined: box-average per REQ-020/021.
- Undefined: decimation. The accumulator bank is not built; the write fires the cycle after the sample with lx%8=0 and ly%8=0, with oWR_DATA=iDATA of that sample. Address order, FSM and oDONE are unchanged; oDONE follows the address-255 write.

Structure
REQ-029 A shared package SHALL hold:
- Constants GRID=16, CELL_SHIFT=3, WIN=128, ADDR_W=8, PIX_W=10, ACC_W=16.
- The FSM state enum.
REQ-030 Sub-module cell_accum_bank SHALL implement the 16x ACC_W accumulator row (load/add/read by cellX) and SHALL be instantiated only under TEMPLATE_CAPTURE_AVG_EN.

Verification
REQ-031 Scenario: constant frame, iDATA=429, X0=Y0=0, AVG_EN defined, iSTART -> 256 writes, addresses 0..255 ascending, all data 429, then a single oDONE.
REQ-032 Scenario: cell (0,0) pixels alternate 0/1023, others 0 -> addr 0 data 511, all other data 0.
REQ-033 Scenario: X0=100, Y0=50, pixel (107,57)=1023 only, AVG_EN undefined -> all data 0 (not a decimation point); set pixel (100,50)=1023 -> addr 0 data 1023.
REQ-034 Scenario: random iDVAL gaps of 0-5 cycles -> results identical to the gap-free run; write latency remains 1 cycle after the triggering sample.
REQ-035 Scenario: frame restart after write 100 -> next write is addr 0; exactly 256 further writes, then oDONE.
REQ-036 Scenario: iRST_N low mid-capture -> outputs 0 at once; iSTART during CAPTURE is ignored, with no second capture.
